// File: rtl/game_flow_ctrl.sv
// Phase sequencer for the symbol-counting game: IDLE -> PRE -> GAME -> ANSWER -> JUDGE -> POST.
// Optional lives/replay support is compiled in with `define GAME_FLOW_LIVES_EN.
module game_flow_ctrl #(
    parameter int NUM_LEVELS  = 8,
    parameter int PRE_SECS    = 3,
    parameter int GAME_SECS   = 10,
    parameter int ANSWER_SECS = 5,
    parameter int POST_SECS   = 2,
    parameter int TOL         = 0,
    parameter int DIFF_W      = 5,
    parameter int PER_W       = 32,
    parameter int BASE_PER    = 100000000,
    parameter int STEP_PER    = 10000000,
    parameter int MIN_PER     = 20000000,
    parameter int LIVES       = 3,
    localparam int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic              Clk100M,
    input  logic              reset,
    input  logic              tick1Hz,
    input  logic              startBtn,
    input  logic [DIFF_W-1:0] difference,
    input  logic              diffValid,
    output logic              pre,
    output logic              game,
    output logic              answer,
    output logic              post,
    output logic              startGen,
    output logic              stopGen,
    output logic              stopCount,
    output logic [LVL_W-1:0]  curLevel,
    output logic [PER_W-1:0]  symGenMax,
    output logic [7:0]        secsLeft,
    output logic              lose,
    output logic              win,
    output logic [1:0]        livesLeft
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_GAME, S_ANSWER, S_JUDGE, S_POST, S_LOSE, S_WIN
    } state_t;

`ifdef GAME_FLOW_LIVES_EN
    localparam bit LIVES_EN_BIT = 1'b1;
`else
    localparam bit LIVES_EN_BIT = 1'b0;
`endif

    localparam logic [1:0]       LIVES_INIT = LIVES_EN_BIT ? 2'(LIVES) : 2'd0;
    localparam logic [LVL_W-1:0] LAST_LVL   = LVL_W'(NUM_LEVELS - 1);
    localparam int               PW         = PER_W + LVL_W + 1;

    state_t           r_state, w_state_next;
    logic [LVL_W-1:0] r_level, w_level_next;
    logic [7:0]       r_secs, w_secs_next;
    logic [1:0]       r_lives, w_lives_next;
    logic             r_lose, w_lose_next;
    logic             r_win, w_win_next;
    logic             r_pre, r_game, r_answer, r_post;
    logic             r_start_gen, r_stop_gen, r_stop_cnt;
    logic [PER_W-1:0] r_sym, w_sym_next;

    logic             w_timed;
    logic             w_tick_last;
    logic             w_pass;
    logic [PW-1:0]    w_prod;
    logic [PW-1:0]    w_base;
    logic [PW-1:0]    w_sub;

    assign w_timed     = (r_state == S_PRE) || (r_state == S_GAME) ||
                         (r_state == S_ANSWER) || (r_state == S_POST);
    assign w_tick_last = tick1Hz && (r_secs == 8'd1);
    assign w_pass      = (32'(difference) <= 32'(TOL));

    // Wide enough that a product larger than BASE_PER is detected rather than wrapped.
    assign w_prod = PW'(r_level) * PW'(STEP_PER);
    assign w_base = PW'(BASE_PER);
    assign w_sub  = w_base - w_prod;

    always_comb begin
        w_sym_next = r_sym;
        if ((w_prod > w_base) || (w_sub < PW'(MIN_PER)))
            w_sym_next = PER_W'(MIN_PER);
        else
            w_sym_next = PER_W'(w_sub);
    end

    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_secs_next  = r_secs;
        w_lives_next = r_lives;
        w_lose_next  = r_lose;
        w_win_next   = r_win;

        if (w_timed && tick1Hz && (r_secs > 8'd1))
            w_secs_next = r_secs - 8'd1;

        case (r_state)
            S_IDLE, S_LOSE, S_WIN: begin
                if (startBtn) begin
                    w_state_next = S_PRE;
                    w_level_next = '0;
                    w_lose_next  = 1'b0;
                    w_win_next   = 1'b0;
                    w_lives_next = LIVES_INIT;
                    w_secs_next  = 8'(PRE_SECS);
                end
            end
            S_PRE: begin
                if (w_tick_last) begin
                    w_state_next = S_GAME;
                    w_secs_next  = 8'(GAME_SECS);
                end
            end
            S_GAME: begin
                if (w_tick_last) begin
                    w_state_next = S_ANSWER;
                    w_secs_next  = 8'(ANSWER_SECS);
                end
            end
            S_ANSWER: begin
                if (w_tick_last) begin
                    w_state_next = S_JUDGE;
                    w_secs_next  = 8'd0;
                end
            end
            S_JUDGE: begin
                if (diffValid) begin
                    if (w_pass) begin
                        if (r_level == LAST_LVL) begin
                            w_state_next = S_WIN;
                            w_win_next   = 1'b1;
                        end else begin
                            w_state_next = S_POST;
                            w_level_next = r_level + 1'b1;
                            w_secs_next  = 8'(POST_SECS);
                        end
`ifdef GAME_FLOW_LIVES_EN
                    end else if (r_lives > 2'd1) begin
                        // A spare life replays the same level.
                        w_state_next = S_POST;
                        w_lives_next = r_lives - 2'd1;
                        w_secs_next  = 8'(POST_SECS);
                    end else begin
                        w_state_next = S_LOSE;
                        w_lives_next = 2'd0;
                        w_lose_next  = 1'b1;
                    end
`else
                    end else begin
                        w_state_next = S_LOSE;
                        w_lose_next  = 1'b1;
                    end
`endif
                end
            end
            S_POST: begin
                if (w_tick_last) begin
                    w_state_next = S_PRE;
                    w_secs_next  = 8'(PRE_SECS);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_level     <= '0;
            r_secs      <= 8'd0;
            r_lives     <= LIVES_INIT;
            r_lose      <= 1'b0;
            r_win       <= 1'b0;
            r_pre       <= 1'b0;
            r_game      <= 1'b0;
            r_answer    <= 1'b0;
            r_post      <= 1'b0;
            r_start_gen <= 1'b0;
            r_stop_gen  <= 1'b0;
            r_stop_cnt  <= 1'b0;
            r_sym       <= PER_W'(BASE_PER);
        end else begin
            r_state     <= w_state_next;
            r_level     <= w_level_next;
            r_secs      <= w_secs_next;
            r_lives     <= w_lives_next;
            r_lose      <= w_lose_next;
            r_win       <= w_win_next;
            // Flags are registered from the next state so they switch together with it.
            r_pre       <= (w_state_next == S_PRE);
            r_game      <= (w_state_next == S_GAME);
            r_answer    <= (w_state_next == S_ANSWER) || (w_state_next == S_JUDGE);
            r_post      <= (w_state_next == S_POST);
            r_start_gen <= (w_state_next == S_GAME) && (r_state != S_GAME);
            r_stop_gen  <= (r_state == S_GAME) && (w_state_next != S_GAME);
            r_stop_cnt  <= (r_state == S_ANSWER) && (w_state_next != S_ANSWER);
            r_sym       <= w_sym_next;
        end
    end

    assign pre       = r_pre;
    assign game      = r_game;
    assign answer    = r_answer;
    assign post      = r_post;
    assign startGen  = r_start_gen;
    assign stopGen   = r_stop_gen;
    assign stopCount = r_stop_cnt;
    assign curLevel  = r_level;
    assign symGenMax = r_sym;
    assign secsLeft  = r_secs;
    assign lose      = r_lose;
    assign win       = r_win;
    assign livesLeft = r_lives;

endmodule
